// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
// Holds the controller state encoding and the default operand width.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width; a one-bit counter is kept for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into Acc,
// then arithmetic right shift of {Acc, Q, q_1} by one bit.
module booth_step #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH:0]   i_acc,
  input  logic        [WIDTH-1:0] i_q,
  input  logic                    i_q1,
  input  logic signed [WIDTH-1:0] i_m,
  output logic signed [WIDTH:0]   o_acc,
  output logic        [WIDTH-1:0] o_q,
  output logic                    o_q1
);

  logic signed [WIDTH:0] w_m_ext;
  logic signed [WIDTH:0] w_sum;

  assign w_m_ext = {i_m[WIDTH-1], i_m};

  always_comb begin
    w_sum = i_acc;
    case ({i_q[0], i_q1})
      2'b01:   w_sum = i_acc + w_m_ext;
      2'b10:   w_sum = i_acc - w_m_ext;
      default: w_sum = i_acc;
    endcase
  end

  // Shift keeps the sign of the widened accumulator in its MSB.
  assign o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign o_q   = {w_sum[0], i_q[WIDTH-1:1]};
  assign o_q1  = i_q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed multiplier: one Booth step per cycle, WIDTH steps per
// product, registered result with a one-cycle done pulse.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   A,
  input  logic signed [WIDTH-1:0]   B,
  output logic signed [2*WIDTH-1:0] Y,
  output logic                      busy,
  output logic                      done
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic signed [WIDTH:0]   r_acc;
  logic        [WIDTH-1:0] r_q;
  logic                    r_q1;
  logic signed [WIDTH-1:0] r_m;
  logic        [CNT_W-1:0] r_count;

  logic signed [WIDTH:0]   w_acc_nxt;
  logic        [WIDTH-1:0] w_q_nxt;
  logic                    w_q1_nxt;
  logic                    w_load;
  logic                    w_step;
  logic                    w_last;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_q1  (r_q1),
    .i_m   (r_m),
    .o_acc (w_acc_nxt),
    .o_q   (w_q_nxt),
    .o_q1  (w_q1_nxt)
  );

  assign w_load = (r_state == IDLE) && start;
  assign w_step = (r_state == CALC);
  assign w_last = w_step && (r_count == LAST_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (r_count == LAST_STEP) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands are only captured from IDLE, so later A/B/start activity is inert.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_m     <= '0;
      r_count <= '0;
      Y       <= '0;
    end else if (w_load) begin
      r_acc   <= '0;
      r_q     <= B;
      r_q1    <= 1'b0;
      r_m     <= A;
      r_count <= '0;
    end else if (w_step) begin
      r_acc   <= w_acc_nxt;
      r_q     <= w_q_nxt;
      r_q1    <= w_q1_nxt;
      r_count <= r_count + CNT_W'(1);
      if (w_last) begin
        Y <= {w_acc_nxt[WIDTH-1:0], w_q_nxt};
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed corners plus random
// operand pairs against a plain signed-multiply reference.
module tb_booth_mult_seq;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic [2*W-1:0] y_out;
  logic           busy;
  logic           done;

  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0] model_y;

  booth_mult_seq #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .Y     (y_out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[2*W-1:0];
  endfunction

  // One operation from IDLE; optionally disturb operands and re-pulse start mid-run.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
    logic [2*W-1:0] exp_y;
    int busy_cnt;
    exp_y = ref_mul(a, b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    chk("busy_after_start", busy, 1'b1);
    chk("done_after_start", done, 1'b0);
    if (disturb) begin
      a_in = 8'h55;
      b_in = 8'h55;
    end
    for (int k = 1; k <= W + 1; k++) begin
      if (disturb && k == 3) start = 1'b1;
      if (disturb && k == 5) start = 1'b0;
      tick();
      if (busy) busy_cnt++;
      chk("done_timing", done, (k == W));
      chk("busy_timing", busy, (k <= W));
      if (k < W) chk("y_hold_calc", y_out, model_y);
      else       chk("y_product", y_out, exp_y);
    end
    model_y = exp_y;
    chk("busy_cycles", busy_cnt, W + 1);
    a_in = a ^ 8'hA5;
    b_in = b ^ 8'h3C;
    tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_y_hold", y_out, model_y);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    a_in    = '0;
    b_in    = '0;
    model_y = '0;
    #3;
    chk("rst_y", y_out, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_op(8'd3, 8'd5, 1'b0);
    chk("y_3x5", y_out, 16'h000F);
    run_op(8'h80, 8'h80, 1'b0);
    chk("y_min_x_min", y_out, 16'h4000);
    run_op(8'h80, 8'h7F, 1'b0);
    chk("y_min_x_max", y_out, 16'hC080);
    run_op(8'h00, 8'hB3, 1'b0);
    chk("y_zero", y_out, 16'h0000);
    run_op(8'hF9, 8'h06, 1'b1);
    chk("y_disturbed", y_out, 16'hFFD6);

    // Asynchronous reset with count at 4.
    a_in  = 8'd9;
    b_in  = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_y", y_out, 16'h0000);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    model_y = '0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", busy, 1'b0);
    run_op(8'd2, 8'd2, 1'b0);
    chk("y_after_rst", y_out, 16'h0004);

    // start held high: back-to-back products every W+2 cycles.
    a_in  = 8'd10;
    b_in  = 8'hF6;
    start = 1'b1;
    tick();
    for (int k = 1; k <= 29; k++) begin
      tick();
      chk("b2b_done", done, ((k % (W + 2)) == W));
      if ((k % (W + 2)) == W) chk("b2b_y", y_out, 16'hFF9C);
      if (k == 29) start = 1'b0;
    end
    tick();
    chk("b2b_stop", busy, 1'b0);
    model_y = 16'hFF9C;

    run_op(8'h7F, 8'h7F, 1'b0);
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < 200; i++) begin
      run_op(W'($urandom), W'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (signed two's complement).
REQ-002 Port clk, input, 1 bit: the single system clock; all state SHALL be updated on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request to begin a multiplication, sampled only in IDLE.
REQ-005 Port A, input, WIDTH bits: signed multiplicand, captured with start.
REQ-006 Port B, input, WIDTH bits: signed multiplier, captured with start.
REQ-007 Port Y, output, 2*WIDTH bits: signed product, registered.
REQ-008 Port busy, output, 1 bit: high while an operation is in progress (CALC or DONE).
REQ-009 Port done, output, 1 bit: single-cycle pulse marking Y valid; feeds the storage stage's mul_valid, and Y feeds mul_result.

Function
REQ-010 The state machine SHALL have exactly three states: IDLE, CALC and DONE.
REQ-011 In IDLE with start=1, the next clock edge SHALL capture the operands, initialise the datapath and enter CALC.
- M <= A
- Q <= B
- Acc <= 0 (WIDTH+1 bits)
- q_1 <= 0
- count <= 0
REQ-012 In IDLE with start=0, all registers SHALL hold, and Y SHALL keep the last product.
REQ-013 Each CALC cycle SHALL perform one radix-2 Booth step on the pair {Q[0], q_1}:
- 01: Acc + M (M sign-extended to WIDTH+1 bits)
- 10: Acc - M (M sign-extended to WIDTH+1 bits)
- 00 or 11: no add
- Then arithmetic right shift of {Acc, Q, q_1} by one bit, with Acc's MSB replicated.
REQ-014 Acc SHALL be WIDTH+1 bits wide so that subtracting the most-negative M (-2^(WIDTH-1)) cannot overflow.
REQ-015 count SHALL increment once per CALC cycle.
- After the step with count = WIDTH-1, the FSM SHALL enter DONE.
- Y SHALL be loaded with {Acc[WIDTH-1:0], Q} taken after that final shift.
REQ-016 In DONE, done SHALL be 1 for exactly that one cycle, and the next state SHALL be IDLE unconditionally.
REQ-017 Latency: with start sampled at edge 0, done SHALL be high during the cycle following edge WIDTH (8 cycles for WIDTH=8), and Y SHALL be valid from edge WIDTH onward.
REQ-018 busy SHALL be 1 in CALC and DONE, and 0 in IDLE.
REQ-019 start asserted in CALC or DONE SHALL be ignored; no operand capture and no restart.
REQ-020 If start is held high continuously, a new operation SHALL begin on the first edge back in IDLE.
- Back-to-back operations are therefore spaced WIDTH+2 cycles apart.
REQ-021 Changes on A or B after capture SHALL NOT affect the running operation.
REQ-022 Y SHALL change only on the transition into DONE, and on reset.
REQ-023 The product SHALL be exact for all signed operand pairs, including -2^(WIDTH-1) * -2^(WIDTH-1).

Reset
REQ-024 When rst=1, the block SHALL immediately, without waiting for a clock edge, force:
- state = IDLE
- Y = 0
- busy = 0
- done = 0
- Acc, Q, q_1, M and count = 0
REQ-025 Reset asserted mid-CALC SHALL abort the operation with no done pulse. The first start after rst deasserts SHALL begin a fresh operation.

Structure
REQ-026 A shared package booth_pkg SHALL hold:
- the state enum type (IDLE, CALC, DONE)
- the default operand width constant (8)
REQ-027 One combinational sub-module booth_step SHALL implement the add/subtract plus arithmetic shift of REQ-013.
- Inputs: Acc, Q, q_1, M.
- Outputs: next Acc, next Q, next q_1.
REQ-028 No other sub-modules are required; the FSM, counter and registers SHALL reside in booth_mult_seq.

Verification
REQ-029 A=3, B=5, start pulsed one cycle -> done high exactly 9 cycles after the start edge's cycle (per REQ-017), Y=15 (0x000F), busy high for 9 cycles.
REQ-030 A=-128, B=-128 -> Y=16384 (0x4000); A=-128, B=127 -> Y=-16256 (0xC080); A=0, B=-77 -> Y=0.
REQ-031 A=-7, B=6 with A and B changed to 0x55 mid-operation, plus start re-pulsed during CALC -> Y=-42 (0xFFD6), exactly one done pulse, no restart.
REQ-032 rst asserted asynchronously in CALC count=4 -> Y=0, busy=0 and done=0 immediately. A subsequent start with A=2, B=2 -> Y=4.
REQ-033 start held high with A=10, B=-10 -> done pulses every 10 cycles, Y=-100 (0xFF9C) each time.
REQ-034 Exhaustive sweep of all 65536 operand pairs against a behavioural signed reference -> zero mismatches, with done and Y checked per REQ-017.
